// File: rtl/share_pkg.sv
// Shared opcode and sequencer-state encodings for the ALU chain controller.
package share_pkg;

  typedef enum logic [2:0] {
    ADD      = 3'd0,
    SUBTRACT = 3'd1,
    AND_OP   = 3'd2,
    OR_OP    = 3'd3,
    XOR_OP   = 3'd4,
    NOT_OP   = 3'd5,
    LOAD     = 3'd7
  } instruction_code;

  typedef enum logic [1:0] {IDLE, FIRST, EXEC, DONE} chain_state_t;

endpackage

// File: rtl/alu_chain_ctrl_alu.sv
// Combinational ALU folded by the chain controller; unlisted codes behave as LOAD.
module alu
  import share_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int OPCODE_WIDTH = 3
) (
  input  logic [OPCODE_WIDTH-1:0] op,
  input  logic [DATA_WIDTH-1:0]   i_1,
  input  logic [DATA_WIDTH-1:0]   i_2,
  input  logic                    carry_in,
  output logic [DATA_WIDTH-1:0]   o_main,
  output logic                    carry_out
);

  logic [DATA_WIDTH:0] sum;

  always_comb begin
    sum       = {1'b0, i_1} + {1'b0, i_2} + {{DATA_WIDTH{1'b0}}, carry_in};
    o_main    = i_2;
    carry_out = carry_in;
    case (op)
      OPCODE_WIDTH'(ADD): begin
        o_main    = sum[DATA_WIDTH-1:0];
        carry_out = sum[DATA_WIDTH];
      end
      OPCODE_WIDTH'(SUBTRACT): begin
        o_main    = i_1 - i_2 + {{(DATA_WIDTH-1){1'b0}}, carry_in};
        carry_out = 1'b0;
      end
      OPCODE_WIDTH'(AND_OP): begin o_main = i_1 & i_2; carry_out = 1'b0; end
      OPCODE_WIDTH'(OR_OP):  begin o_main = i_1 | i_2; carry_out = 1'b0; end
      OPCODE_WIDTH'(XOR_OP): begin o_main = i_1 ^ i_2; carry_out = 1'b0; end
      // Operand is consumed but ignored; only the accumulator is inverted.
      OPCODE_WIDTH'(NOT_OP): begin o_main = ~i_1;      carry_out = 1'b0; end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_chain_ctrl.sv
// Sequencer folding cmd_len operands through one ALU into an accumulator.
module alu_chain_ctrl
  import share_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int OPCODE_WIDTH = 3,
  parameter int LEN_WIDTH    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [OPCODE_WIDTH-1:0] cmd_op,
  input  logic [LEN_WIDTH-1:0]    cmd_len,
  input  logic                    cmd_carry_in,
  input  logic                    opd_valid,
  output logic                    opd_ready,
  input  logic [DATA_WIDTH-1:0]   opd_data,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [DATA_WIDTH-1:0]   res_data,
  output logic                    res_carry,
  output logic                    res_err,
  output logic                    busy
);

  chain_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0]   acc_q, acc_d;
  logic                    carry_q, carry_d;
  logic [LEN_WIDTH-1:0]    rem_q, rem_d;
  logic [OPCODE_WIDTH-1:0] op_q, op_d;
  logic                    err_q, err_d;

  logic [OPCODE_WIDTH-1:0] alu_op;
  logic [DATA_WIDTH-1:0]   alu_out;
  logic                    alu_cout;

  // The first operand is always loaded so a chain never sees a stale accumulator.
  assign alu_op = (state_q == FIRST) ? OPCODE_WIDTH'(LOAD) : op_q;

  alu #(
    .DATA_WIDTH  (DATA_WIDTH),
    .OPCODE_WIDTH(OPCODE_WIDTH)
  ) u_alu (
    .op       (alu_op),
    .i_1      (acc_q),
    .i_2      (opd_data),
    .carry_in (carry_q),
    .o_main   (alu_out),
    .carry_out(alu_cout)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    rem_d   = rem_q;
    op_d    = op_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        op_d    = cmd_op;
        rem_d   = cmd_len;
        carry_d = cmd_carry_in;
        acc_d   = '0;
        err_d   = (cmd_len == '0);
        state_d = (cmd_len == '0) ? DONE : FIRST;
      end
      FIRST, EXEC: if (opd_valid) begin
        acc_d   = alu_out;
        carry_d = alu_cout;
        rem_d   = rem_q - 1'b1;
        state_d = (rem_q == LEN_WIDTH'(1)) ? DONE : EXEC;
      end
      DONE: if (res_ready) begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      carry_q <= 1'b0;
      rem_q   <= '0;
      op_q    <= OPCODE_WIDTH'(LOAD);
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      err_q   <= err_d;
    end
  end

  // All handshake outputs decode registered state only, so res_ready never reaches cmd_ready.
  assign cmd_ready = (state_q == IDLE);
  assign opd_ready = (state_q == FIRST) || (state_q == EXEC);
  assign res_valid = (state_q == DONE);
  assign res_data  = res_valid ? acc_q : '0;
  assign res_carry = res_valid & carry_q;
  assign res_err   = res_valid & err_q;
  assign busy      = (state_q != IDLE);

endmodule
